// File: rtl/lsm_addr_seq.sv
// Load/store address-generation sequencer: decodes one instruction, issues one address per beat, then writeback.
// Optional alignment abort for single transfers when LSM_ALIGN_CHECK_EN is defined.
module lsm_addr_seq #(
  parameter int AW    = 32,
  parameter int NREGS = 16,
  parameter int STEP  = 4
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          START,
  input  logic [31:0]   OPCODE,
  input  logic [AW-1:0] BASE,
  input  logic [AW-1:0] OFFSET,
  input  logic          READY,
  output logic [AW-1:0] ADDR,
  output logic          ADDR_VALID,
  output logic [3:0]    REG_IDX,
  output logic          LAST,
  output logic          WB_EN,
  output logic [AW-1:0] WB_DATA,
  output logic          BUSY,
  output logic          DONE,
  output logic          ALIGN_ERR
);

  typedef enum logic [1:0] {IDLE, XFER, WB} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [3:0]       reg_idx_q, reg_idx_d;
  logic             last_q, last_d;
  logic [NREGS-1:0] mask_q, mask_d;
  logic             wb_pend_q, wb_pend_d;
  logic [AW-1:0]    wb_val_q, wb_val_d;

  function automatic logic [4:0] popcnt(input logic [NREGS-1:0] m);
    popcnt = '0;
    for (int i = 0; i < NREGS; i++) popcnt = popcnt + 5'(m[i]);
  endfunction

  function automatic logic [3:0] lsb_idx(input logic [NREGS-1:0] m);
    lsb_idx = '0;
    for (int i = NREGS - 1; i >= 0; i--) if (m[i]) lsb_idx = 4'(i);
  endfunction

  logic             is_single, is_half, is_block, is_branch;
  logic [NREGS-1:0] list_c, list_rest_c, mask_rest_c;
  logic [4:0]       nregs_c;
  logic [AW-1:0]    off_c, sum_c, sx_addr_c, stepn_c, blk_raw_c, blk_wb_c, addr_inc_c;
  logic             aerr_c;
  logic             unused_bits;

  assign unused_bits = ^{OPCODE[31:28], OPCODE[20:16]};

  always_comb begin
    is_single   = (OPCODE[27:26] == 2'b01);
    is_half     = (OPCODE[27:25] == 3'b000) && OPCODE[7] && OPCODE[4];
    is_block    = (OPCODE[27:25] == 3'b100);
    is_branch   = (OPCODE[27:25] == 3'b101);
    list_c      = OPCODE[NREGS-1:0];
    list_rest_c = list_c & (list_c - NREGS'(1));
    mask_rest_c = mask_q & (mask_q - NREGS'(1));
    nregs_c     = popcnt(list_c);
    stepn_c     = AW'(STEP) * AW'(nregs_c);
    if (is_half) off_c = OPCODE[22] ? AW'({OPCODE[11:8], OPCODE[3:0]}) : OFFSET;
    else         off_c = OPCODE[25] ? OFFSET : AW'(OPCODE[11:0]);
    sum_c     = OPCODE[23] ? (BASE + off_c) : (BASE - off_c);
    sx_addr_c = OPCODE[24] ? sum_c : BASE;
    // Block start address by {P,U}: DA/IA/DB/IB.
    case ({OPCODE[24], OPCODE[23]})
      2'b01:   blk_raw_c = BASE;
      2'b11:   blk_raw_c = BASE + AW'(STEP);
      2'b00:   blk_raw_c = BASE - stepn_c + AW'(STEP);
      default: blk_raw_c = BASE - stepn_c;
    endcase
    blk_wb_c   = OPCODE[23] ? (BASE + stepn_c) : (BASE - stepn_c);
    addr_inc_c = addr_q + AW'(STEP);
  end

`ifdef LSM_ALIGN_CHECK_EN
  logic aerr_q, aerr_d;
  // Word needs 4-byte alignment; halfword (H bit set) needs 2-byte; bytes are never checked.
  assign aerr_c = (is_single && !OPCODE[22] && (sx_addr_c[1:0] != 2'b00)) ||
                  (is_half && OPCODE[5] && sx_addr_c[0]);
  assign ALIGN_ERR = (state_q == WB) && aerr_q;
`else
  assign aerr_c    = 1'b0;
  assign ALIGN_ERR = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    reg_idx_d = reg_idx_q;
    last_d    = last_q;
    mask_d    = mask_q;
    wb_pend_d = wb_pend_q;
    wb_val_d  = wb_val_q;
`ifdef LSM_ALIGN_CHECK_EN
    aerr_d    = aerr_q;
`endif
    case (state_q)
      IDLE: begin
        if (START) begin
          state_d   = WB;
          wb_pend_d = 1'b0;
          if (is_single || is_half) begin
            if (aerr_c) begin
`ifdef LSM_ALIGN_CHECK_EN
              aerr_d = 1'b1;
`endif
            end else begin
              state_d   = XFER;
              addr_d    = sx_addr_c;
              reg_idx_d = OPCODE[15:12];
              last_d    = 1'b1;
              mask_d    = '0;
              wb_pend_d = !OPCODE[24] || OPCODE[21];
              wb_val_d  = sum_c;
            end
          end else if (is_block && (list_c != '0)) begin
            state_d   = XFER;
            addr_d    = {blk_raw_c[AW-1:2], 2'b00};
            reg_idx_d = lsb_idx(list_c);
            mask_d    = list_rest_c;
            last_d    = (nregs_c == 5'd1);
            wb_pend_d = OPCODE[21];
            wb_val_d  = blk_wb_c;
          end else if (is_branch) begin
            wb_pend_d = 1'b1;
            wb_val_d  = BASE + OFFSET;
          end
        end
      end
      XFER: begin
        if (READY) begin
          if (last_q) begin
            state_d = WB;
          end else begin
            addr_d    = {addr_inc_c[AW-1:2], 2'b00};
            reg_idx_d = lsb_idx(mask_q);
            mask_d    = mask_rest_c;
            last_d    = (mask_rest_c == '0);
          end
        end
      end
      WB: begin
        state_d   = IDLE;
        wb_pend_d = 1'b0;
`ifdef LSM_ALIGN_CHECK_EN
        aerr_d    = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      reg_idx_q <= '0;
      last_q    <= 1'b0;
      mask_q    <= '0;
      wb_pend_q <= 1'b0;
      wb_val_q  <= '0;
`ifdef LSM_ALIGN_CHECK_EN
      aerr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      reg_idx_q <= reg_idx_d;
      last_q    <= last_d;
      mask_q    <= mask_d;
      wb_pend_q <= wb_pend_d;
      wb_val_q  <= wb_val_d;
`ifdef LSM_ALIGN_CHECK_EN
      aerr_q    <= aerr_d;
`endif
    end
  end

  assign ADDR       = addr_q;
  assign ADDR_VALID = (state_q == XFER);
  assign REG_IDX    = reg_idx_q;
  assign LAST       = last_q;
  assign BUSY       = (state_q != IDLE);
  assign DONE       = (state_q == WB);
  assign WB_EN      = DONE && wb_pend_q;
  assign WB_DATA    = WB_EN ? wb_val_q : '0;

endmodule

// File: doc/lsm_addr_seq.md
# lsm_addr_seq

Parametrised address-generation sequencer for the load/store unit. It decodes a load/store instruction once, then issues one address per memory beat under a valid/ready handshake. It covers single word/byte and halfword transfers with pre/post-indexing, and LDM/STM block transfers in all four addressing modes. It returns the base-register writeback value and branch targets to the register file. It sits between the decode stage (OPCODE, BASE, OFFSET) and the data-memory port.

## Interface
- AW, 32, address/data width of BASE, OFFSET, ADDR, WB_DATA
- NREGS, 16, register-list width (OPCODE[NREGS-1:0]); 1..16
- STEP, 4, byte increment per block-transfer beat
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- START  in  1  one-cycle request; sampled only in IDLE
- OPCODE  in  32  instruction word, captured on accepted START
- BASE  in  AW  base register (Rn) value
- OFFSET  in  AW  register offset (Rm) value
- READY  in  1  memory accepts the current beat
- ADDR  out  AW  beat address
- ADDR_VALID  out  1  ADDR is valid, held until READY
- REG_IDX  out  4  register number for the current beat
- LAST  out  1  current beat is the final one
- WB_EN  out  1  WB_DATA is to be written (base Rn, or PC for branch)
- WB_DATA  out  AW  writeback value / branch target
- BUSY  out  1  request in progress
- DONE  out  1  one-cycle completion pulse
- ALIGN_ERR  out  1  misalignment abort; only present with the macro, otherwise tied 0

## Operation
- States: IDLE, XFER, WB.
  - IDLE --START--> XFER, or WB directly if the request has zero beats.
  - XFER --last beat accepted--> WB.
  - WB --> IDLE.
- OPCODE, BASE and OFFSET are registered on the accepted START; later input changes are ignored.
- Single transfer, OPCODE[27:26]=01, 1 beat:
  - Offset: bit25=0 selects zero-extended OPCODE[11:0]; bit25=1 selects OFFSET.
  - Direction: bit23=1 adds the offset, 0 subtracts it.
  - Addressing: bit24=1 is pre-index (ADDR = BASE±off); bit24=0 is post-index (ADDR = BASE).
  - WB_EN is set when (bit24=0) or (bit21=1), with WB_DATA = BASE±off.
- Halfword/signed, OPCODE[27:25]=000 with [7]=1 and [4]=1, 1 beat:
  - bit22=1 selects offset {OPCODE[11:8],OPCODE[3:0]}; bit22=0 selects OFFSET.
  - Indexing and writeback rules are the same as for single transfers.
- Block transfer, OPCODE[27:25]=100:
  - n = popcount(OPCODE[NREGS-1:0]).
  - Start address by mode {bit24,bit23}: IA=BASE, IB=BASE+STEP, DA=BASE−STEP·n+STEP, DB=BASE−STEP·n.
  - Beats are issued in ascending register order; ADDR increments by STEP per beat.
  - ADDR[1:0] is forced to 00.
  - Writeback when bit21=1: WB_DATA = BASE±STEP·n.
  - n=0: no beats, no writeback, DONE only.
- Branch, OPCODE[27:25]=101: no beats; WB_EN=1 with WB_DATA = BASE+OFFSET.
- Any other class: no beats, no writeback, DONE only.
- All arithmetic is modulo 2^AW; wrap-around is silent.

## Timing
- Reset value of every output: 0. State resets to IDLE. Reset asserted mid-transfer aborts immediately, with no DONE and no writeback.
- An accepted START raises BUSY on the next edge. For beat requests, ADDR_VALID also rises on that edge with the first ADDR, REG_IDX and LAST.
- A beat completes on an edge where ADDR_VALID=READY=1. The next beat is presented on that same edge, so back-to-back READY gives 1 beat/cycle.
- While READY=0, ADDR, REG_IDX and LAST hold stable.
- WB lasts exactly one cycle, asserting DONE and (if applicable) WB_EN/WB_DATA. BUSY is high through the WB cycle and falls on the next edge.
- Latency with READY held high: n+2 cycles from START to DONE; zero-beat requests take 2.
- START while BUSY=1 is ignored. A new START is accepted in the cycle after DONE.

## Configuration
- LSM_ALIGN_CHECK_EN defined:
  - Single transfers check alignment before issuing the beat. Word (bit22=0, class 01) needs ADDR[1:0]=00; halfword needs ADDR[0]=0.
  - On failure: no beat, go straight to WB with DONE=1, ALIGN_ERR=1, WB_EN=0.
  - Byte transfers are never checked.
- LSM_ALIGN_CHECK_EN undefined: no checking; misaligned addresses are issued unchanged; ALIGN_ERR is constant 0.

## Test plan
- LDR pre-index with writeback: OPCODE=0xE5B1_0010, BASE=0x1000 -> one beat at ADDR=0x1010; WB_EN=1, WB_DATA=0x1010; DONE at cycle 3.
- LDRH post-index register-down: OPCODE=0xE011_00B2, BASE=0x2000, OFFSET=0x6 -> ADDR=0x2000; WB_DATA=0x1FFA.
- LDMIA, list 0x8005, BASE=0x1000, READY low for 2 cycles on beat 2 -> beats 0x1000/R0, 0x1004/R2 (held stable through the stall), 0x1008/R15 with LAST=1; no writeback.
- STMDB with W, list 0x00F0, BASE=0x2000 -> beats 0x1FF0, 0x1FF4, 0x1FF8, 0x1FFC for R4–R7; WB_DATA=0x1FF0.
- Empty LDM list, a branch with BASE=0x100 and OFFSET=0x40 (-> WB_DATA=0x140), and START asserted while BUSY -> correct DONE timing in each case; the busy START is ignored.
- RST_N low after beat 1 of a 4-beat LDM -> all outputs 0 immediately. With LSM_ALIGN_CHECK_EN, LDR at 0x1002 -> DONE and ALIGN_ERR, no ADDR_VALID.
